// File: rtl/mst_tlp_tx_if.sv
// FIFO read port and ECP3 PCIe transmit port of the master TLP engine.
// master = TLP engine side, slave = FIFO/PCIe core side.
interface mst_tlp_tx_if;
   logic [17:0] mst_dout;
   logic        mst_empty;
   logic        mst_rd_en;
   logic        tx_req;
   logic        tx_rdy;
   logic        tx_st;
   logic        tx_end;
   logic [15:0] tx_data;
   logic [8:0]  tx_ca_ph;
   logic [12:0] tx_ca_pd;

   modport master (
      input  mst_dout, mst_empty,
      input  tx_rdy, tx_ca_ph, tx_ca_pd,
      output mst_rd_en,
      output tx_req, tx_st, tx_end, tx_data
   );

   modport slave (
      output mst_dout, mst_empty,
      output tx_rdy, tx_ca_ph, tx_ca_pd,
      input  mst_rd_en,
      input  tx_req, tx_st, tx_end, tx_data
   );
endinterface

// File: rtl/mst_tlp_tx.sv
// Turns buffered Ethernet write records into posted MWr32 TLPs
// on the 16-bit ECP3 PCIe transmit interface.
module mst_tlp_tx #(
   parameter int MAX_DW = 32
) (
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   input  logic [15:0]  req_id,
   mst_tlp_tx_if.master bus,
   output logic [15:0]  tlp_count,
   output logic [7:0]   drop_count
);
   localparam int DEPTH = 2 * MAX_DW;
   localparam int AW = $clog2(DEPTH);
   localparam int NW = AW + 1;
   localparam logic [NW-1:0] FULL = NW'(DEPTH);
   localparam logic [NW-1:0] ONE = NW'(1);

   typedef enum logic [2:0] {
      IDLE, ADDR, LOAD, ARB, HDR, DATA
   } state_t;

   state_t        state;
   logic          live;
   logic          rd_vld;
   logic          skid_full;
   logic [17:0]   skid;
   logic [NW-1:0] n_cnt;
   logic [NW-1:0] n_nxt;
   logic [NW-1:0] rp;
   logic [2:0]    hidx;
   logic          addr_ph;
   logic [7:0]    cmd;
   logic [7:0]    be;
   logic [7:0]    tag;
   logic [15:0]   addr_hi;
   logic [15:0]   addr_lo;
   logic [9:0]    len;
   logic [9:0]    need;
   logic [15:0]   mem [DEPTH];

   logic          use_skid;
   logic          in_vld;
   logic [17:0]   in_w;
   logic          is_sop;
   logic          is_last;
   logic          wr;
   logic          drop;
   logic          grant;
   logic          rd_en;
   logic [7:0]    be3;
   logic [15:0]   hdr_w;

   logic          tx_req_q;
   logic          tx_st_q;
   logic          tx_end_q;
   logic [15:0]   tx_data_q;

   assign bus.mst_rd_en = rd_en;
   assign bus.tx_req    = tx_req_q;
   assign bus.tx_st     = tx_st_q;
   assign bus.tx_end    = tx_end_q;
   assign bus.tx_data   = tx_data_q;

   // A word parked in the skid register wins over the FIFO on return to IDLE.
   assign use_skid = (state == IDLE) && skid_full;
   assign in_vld   = use_skid || rd_vld;
   assign in_w     = use_skid ? skid : bus.mst_dout;
   assign is_sop   = (in_w[17:16] == 2'b10);
   assign is_last  = (in_w[17:16] == 2'b01);
   assign n_nxt    = n_cnt + ONE;

   assign rd_en = live && !skid_full && !bus.mst_empty &&
                  (state == IDLE || state == ADDR ||
                   state == LOAD);

   assign wr = in_vld && (state == LOAD) &&
               !is_sop && (n_cnt != FULL);

   always_comb begin
      drop = 1'b0;
      if (in_vld && state == ADDR)
         drop = is_sop || is_last;
      else if (in_vld && state == LOAD)
         drop = is_sop || (n_cnt == FULL) ||
                (is_last && (n_nxt[0] || cmd != 8'h90));
   end

   assign need  = (len + 10'd3) >> 2;
   assign grant = bus.tx_rdy && (bus.tx_ca_ph != 9'd0) &&
                  (bus.tx_ca_pd >= {3'b000, need});
   assign be3   = (len == 10'd1) ? {4'h0, be[3:0]} : be;

   always_comb begin
      unique case (1'b1)
         hidx == 3'd1: hdr_w = {6'b0, len};
         hidx == 3'd2: hdr_w = req_id;
         hidx == 3'd3: hdr_w = {tag, be3};
         hidx == 3'd4: hdr_w = addr_hi;
         hidx == 3'd5: hdr_w = addr_lo;
         default:      hdr_w = 16'h4000;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (wr)
         mem[n_cnt[AW-1:0]] <= in_w[15:0];
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         drop_count <= 8'h00;
      else if (drop && drop_count != 8'hff)
         drop_count <= drop_count + 8'd1;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         live      <= 1'b0;
         rd_vld    <= 1'b0;
         skid_full <= 1'b0;
         skid      <= '0;
         n_cnt     <= '0;
         rp        <= '0;
         hidx      <= '0;
         addr_ph   <= 1'b0;
         cmd       <= '0;
         be        <= '0;
         tag       <= '0;
         addr_hi   <= '0;
         addr_lo   <= '0;
         len       <= '0;
         tx_req_q  <= 1'b0;
         tx_st_q   <= 1'b0;
         tx_end_q  <= 1'b0;
         tx_data_q <= '0;
         tlp_count <= '0;
      end else begin
         live     <= 1'b1;
         rd_vld   <= rd_en;
         tx_st_q  <= 1'b0;
         tx_end_q <= 1'b0;
         if (use_skid)
            skid_full <= 1'b0;
         // The read issued alongside the last payload word lands here.
         if (state == ARB && rd_vld) begin
            skid      <= bus.mst_dout;
            skid_full <= 1'b1;
         end
         case (state)
            IDLE: begin
               tx_data_q <= '0;
               if (in_vld && is_sop) begin
                  cmd     <= in_w[15:8];
                  be      <= in_w[7:0];
                  addr_ph <= 1'b0;
                  state   <= ADDR;
               end
            end
            ADDR: begin
               if (in_vld) begin
                  if (is_sop) begin
                     cmd     <= in_w[15:8];
                     be      <= in_w[7:0];
                     addr_ph <= 1'b0;
                  end else if (is_last) begin
                     state <= IDLE;
                  end else if (!addr_ph) begin
                     addr_hi <= in_w[15:0];
                     addr_ph <= 1'b1;
                  end else begin
                     addr_lo <= {in_w[15:2], 2'b00};
                     n_cnt   <= '0;
                     state   <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (in_vld) begin
                  if (is_sop) begin
                     cmd     <= in_w[15:8];
                     be      <= in_w[7:0];
                     addr_ph <= 1'b0;
                     state   <= ADDR;
                  end else if (drop) begin
                     state <= IDLE;
                  end else begin
                     n_cnt <= n_nxt;
                     if (is_last) begin
                        len      <= 10'(n_nxt >> 1);
                        tx_req_q <= 1'b1;
                        state    <= ARB;
                     end
                  end
               end
            end
            ARB: begin
               if (grant) begin
                  tx_req_q  <= 1'b0;
                  tx_st_q   <= 1'b1;
                  tx_data_q <= hdr_w;
                  hidx      <= 3'd1;
                  state     <= HDR;
               end else begin
                  hidx <= 3'd0;
               end
            end
            HDR: begin
               tx_data_q <= hdr_w;
               hidx      <= hidx + 3'd1;
               if (hidx == 3'd5) begin
                  rp    <= '0;
                  state <= DATA;
               end
            end
            DATA: begin
               tx_data_q <= mem[rp[AW-1:0]];
               rp        <= rp + ONE;
               if (rp + ONE == n_cnt) begin
                  tx_end_q  <= 1'b1;
                  tlp_count <= tlp_count + 16'd1;
                  tag       <= tag + 8'd1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mst_tlp_tx.sv
// Scoreboard bench for mst_tlp_tx: FIFO model in, TLP words
// compared against a queue of expected words out.
module tb_mst_tlp_tx;
   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [15:0] req_id = 16'ha5c3;
   logic [15:0] tlp_count;
   logic [7:0]  drop_count;

   mst_tlp_tx_if bus();

   mst_tlp_tx #(.MAX_DW(32)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .req_id     (req_id),
      .bus        (bus.master),
      .tlp_count  (tlp_count),
      .drop_count (drop_count)
   );

   always #5 sys_clk = ~sys_clk;

   logic [17:0] fifo [$];
   logic [17:0] exp_q [$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic [7:0]  m_tag = 8'h00;
   int          exp_tlp = 0;
   int          exp_drop = 0;
   bit          in_tlp = 1'b0;
   int          seen = 0;

   assign bus.mst_empty = (fifo.size() == 0);

   task automatic check(string tag, logic [31:0] got,
                        logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(posedge sys_clk) begin
      if (bus.mst_rd_en && fifo.size() != 0)
         bus.mst_dout <= fifo.pop_front();
   end

   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         in_tlp = 1'b0;
         seen = 0;
      end else if (bus.tx_st || in_tlp) begin
         logic [17:0] w;
         w = {bus.tx_st, bus.tx_end, bus.tx_data};
         if (exp_q.size() == 0)
            check("spurious_word", {14'h0, w}, 32'hdead_beef);
         else
            check("tlp_word", {14'h0, w}, {14'h0, exp_q.pop_front()});
         seen = bus.tx_st ? 1 : seen + 1;
         in_tlp = !bus.tx_end;
      end
   end

   task automatic push_rec(logic [15:0] sop, logic [31:0] addr,
                           int n, bit send);
      logic [15:0] d;
      logic [9:0]  l;
      logic [7:0]  b;
      logic [1:0]  f;
      l = 10'(n / 2);
      b = sop[7:0];
      if (l == 10'd1)
         b[7:4] = 4'h0;
      fifo.push_back({2'b10, sop});
      fifo.push_back({2'b00, addr[31:16]});
      fifo.push_back({2'b00, addr[15:2], 2'b00});
      if (send) begin
         exp_q.push_back({2'b10, 16'h4000});
         exp_q.push_back({2'b00, 6'b0, l});
         exp_q.push_back({2'b00, req_id});
         exp_q.push_back({2'b00, m_tag, b});
         exp_q.push_back({2'b00, addr[31:16]});
         exp_q.push_back({2'b00, addr[15:2], 2'b00});
         m_tag++;
         exp_tlp++;
      end
      for (int i = 0; i < n; i++) begin
         d = 16'($urandom);
         f = (i == n - 1) ? 2'b01 : 2'b00;
         fifo.push_back({f, d});
         if (send)
            exp_q.push_back({1'b0, i == n - 1, d});
      end
   endtask

   task automatic wait_idle(int budget);
      int i;
      i = 0;
      while ((exp_q.size() != 0 || fifo.size() != 0 || in_tlp) &&
             i < budget) begin
         @(negedge sys_clk);
         i++;
      end
      check("timeout_pending",
            exp_q.size() + fifo.size() + int'(in_tlp), 0);
      repeat (8) @(negedge sys_clk);
      check("tlp_count", {16'h0, tlp_count}, exp_tlp);
      check("drop_count", {24'h0, drop_count}, exp_drop);
   endtask

   initial begin
      bit saw;
      int i;
      bus.tx_rdy = 1'b1;
      bus.tx_ca_ph = 9'd4;
      bus.tx_ca_pd = 13'd8;

      // record 1 waits in the FIFO while reset is held
      push_rec(16'h90ff, 32'h1234_5670, 16, 1'b1);
      repeat (3) @(negedge sys_clk);
      check("rst_rd_en", bus.mst_rd_en, 0);
      check("rst_tx_req", bus.tx_req, 0);
      check("rst_tx_st", bus.tx_st, 0);
      check("rst_tx_end", bus.tx_end, 0);
      check("rst_tx_data", bus.tx_data, 0);
      check("rst_tlp_count", tlp_count, 0);
      check("rst_drop_count", drop_count, 0);
      sys_rst_n = 1'b1;
      wait_idle(500);

      // posted data credits short of ceil(L/4)
      bus.tx_ca_pd = 13'd1;
      push_rec(16'h90ff, 32'h1234_5670, 16, 1'b1);
      i = 0;
      while (!bus.tx_req && i < 200) begin
         @(negedge sys_clk);
         i++;
      end
      check("arb_req", bus.tx_req, 1);
      saw = 1'b0;
      repeat (20) begin
         @(negedge sys_clk);
         if (bus.tx_st)
            saw = 1'b1;
      end
      check("no_st_low_credit", saw, 0);
      check("req_held", bus.tx_req, 1);
      bus.tx_ca_pd = 13'd2;
      wait_idle(500);
      bus.tx_ca_pd = 13'd8;

      // back-to-back records through the skid path
      push_rec(16'h90f1, 32'hdead_bee0, 8, 1'b1);
      push_rec(16'h903c, 32'h0bad_c0d4, 6, 1'b1);
      wait_idle(800);

      // drops: odd N, N=0, bad command, SOP inside LOAD
      push_rec(16'h9033, 32'h1000_0000, 3, 1'b0);
      exp_drop++;
      fifo.push_back({2'b10, 16'h90ff});
      fifo.push_back({2'b00, 16'h2000});
      fifo.push_back({2'b01, 16'h0010});
      exp_drop++;
      push_rec(16'h40ff, 32'h3000_0000, 4, 1'b0);
      exp_drop++;
      fifo.push_back({2'b10, 16'h90ff});
      fifo.push_back({2'b00, 16'h4000});
      fifo.push_back({2'b00, 16'h0020});
      fifo.push_back({2'b00, 16'h1111});
      fifo.push_back({2'b00, 16'h2222});
      exp_drop++;
      push_rec(16'h90f0, 32'h5555_aaa8, 4, 1'b1);
      wait_idle(800);

      // reset in the middle of the 4th payload word
      push_rec(16'h90ff, 32'h7777_0000, 8, 1'b1);
      i = 0;
      while (seen < 10 && i < 300) begin
         @(negedge sys_clk);
         #1;
         i++;
      end
      check("rst_wait", seen, 10);
      #1 sys_rst_n = 1'b0;
      #1;
      check("mid_rst_tx_st", bus.tx_st, 0);
      check("mid_rst_tx_end", bus.tx_end, 0);
      check("mid_rst_tx_data", bus.tx_data, 0);
      check("mid_rst_tx_req", bus.tx_req, 0);
      check("mid_rst_rd_en", bus.mst_rd_en, 0);
      check("mid_rst_tlp_count", tlp_count, 0);
      check("mid_rst_drop_count", drop_count, 0);
      fifo.delete();
      exp_q.delete();
      m_tag = 8'h00;
      exp_tlp = 0;
      exp_drop = 0;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;

      // fresh record, L=1 with BE ff -> tag 00 header word 000f
      push_rec(16'h90ff, 32'h0000_1000, 2, 1'b1);
      wait_idle(500);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mst_tlp_tx.md
# mst_tlp_tx

Drains the 18-bit master FIFO written by the Ethernet receive stage. It turns each buffered write record into one PCIe posted Memory Write TLP (3DW header, MWr32) and sends it on the 16-bit transmit interface of the ECP3 PCIe core. The block stages each record internally, derives the TLP length from the record's payload word count, and checks posted credits before requesting the link.

## Interface
- `MAX_DW`, 32: maximum payload in DWs per TLP; staging buffer holds 2*MAX_DW 16-bit words.
- `sys_clk`  in  1  single clock for all logic.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `mst_dout`  in  18  FIFO word. [17:16]=2'b10 marks SOP, 2'b01 marks last payload word, 2'b00 marks any other word.
- `mst_empty`  in  1  FIFO empty.
- `mst_rd_en`  out  1  FIFO read. Data is valid on `mst_dout` the cycle after this is asserted.
- `req_id`  in  16  requester ID {bus, dev, fn} inserted in the header.
- `tx_req`  out  1  transmit request to the PCIe core.
- `tx_rdy`  in  1  core grant.
- `tx_st`  out  1  first TLP word.
- `tx_end`  out  1  last TLP word.
- `tx_data`  out  16  TLP data.
- `tx_ca_ph`  in  9  posted header credits available.
- `tx_ca_pd`  in  13  posted data credits available, in 16-byte units.
- `tlp_count`  out  16  TLPs sent; wraps.
- `drop_count`  out  8  records dropped; saturates at 8'hff.

## Operation
- Record format on `mst_dout[15:0]`:
  - SOP word: [15:8] command, must be 8'h90; [7:0] {last BE, first BE}.
  - Word 2: addr[31:16].
  - Word 3: {addr[15:2], 2'b00}.
  - Then N payload words; the last one carries flag 01.
- States:
  - IDLE: wait for an SOP word. Non-SOP words are discarded.
  - ADDR: capture the two address words.
  - LOAD: write payload words into the staging buffer; count N.
  - ARB: hold `tx_req`=1. Leave ARB when `tx_rdy`=1 and `tx_ca_ph`!=0 and `tx_ca_pd` >= ceil(L/4).
  - HDR: send 6 header words.
  - DATA: send N words.
  - After DATA, return to IDLE.
- Payload length: L = N/2 DWs, 10-bit field.
- Drop the record (increment `drop_count`, go to IDLE) if any of these holds:
  - N odd.
  - N==0.
  - N > 2*MAX_DW.
  - Command != 8'h90.
  - An SOP word arrives in ADDR or LOAD. That SOP word starts a new record (go to ADDR).
- Header words, in order:
  - 16'h4000
  - {6'b0, L}
  - `req_id`
  - {tag, BE}, where the last-BE nibble is forced to 4'h0 when L==1
  - addr[31:16]
  - {addr[15:2], 2'b00}
- `tag` is an 8-bit counter. It increments after each sent TLP and resets to 0.
- Payload is sent in FIFO order. `tx_end` is asserted with the final payload word.

## Timing
- Reset values:
  - `mst_rd_en`, `tx_req`, `tx_st`, `tx_end` = 0.
  - `tx_data` = 16'h0.
  - Counters = 0.
  - tag = 0.
  - State = IDLE.
  - Skid register empty.
- Reads:
  - `mst_rd_en` = !`mst_empty` in IDLE, ADDR and LOAD. Back-to-back reads are allowed.
  - A word returned after the last-flag word (from the read already in flight) goes into a one-entry skid register. It is consumed first on return to IDLE.
  - `mst_rd_en` is 0 whenever the skid register is full.
- Transmit:
  - `tx_req` rises the cycle after LOAD sees the last flag. It falls in the cycle `tx_st` is asserted.
  - `tx_st` is asserted the cycle after the grant condition holds.
  - Words then go out on consecutive cycles with no gaps: 6+N cycles from `tx_st` through `tx_end` inclusive.
  - `tx_rdy` is sampled only in ARB.
- Counter updates:
  - `tlp_count` increments in the cycle `tx_end`=1.
  - `drop_count` updates the cycle after the drop condition is detected.
- `sys_rst_n` low at any time forces the reset values immediately, including mid-TLP. No partial TLP is resumed after reset.
- Minimum record-to-`tx_st` latency with the FIFO pre-filled and credits available: 3+N+3 cycles.

## Test plan
- Record SOP 16'h90ff, addr 0x1234_5670, 16 payload words; `tx_rdy`=1, credits ph=4, pd=8 -> headers 4000, 0008, req_id, 00ff, 1234, 5670, then 16 data words; `tx_end` on word 22; `tlp_count`=1.
- Same record with `tx_ca_pd`=1 for 20 cycles, then 2 -> `tx_req` stays high, no `tx_st` until the credit rises; the TLP is unchanged.
- Two records back-to-back in the FIFO -> both TLPs sent, tags 00 then 01, no lost words (skid path exercised).
- Record with N=3, then N=0, then a second SOP inside LOAD -> `drop_count`=3, no TLP for those records; the record after the second SOP is sent normally.
- Record with N=2 (L=1), SOP BE 8'hff -> header word 3 = 16'h000f.
- Assert `sys_rst_n`=0 at the 4th data word, release, then a fresh record -> outputs return to reset values immediately; the next TLP is complete and uses tag 00.
